// File: rtl/alu_cc_unit.sv
// alu_cc_unit: Y86-64 condition-code register plus jXX/cmovXX condition resolver.
// Latency: flags visible 2 edges after result accept; condition answer registered 1 edge after query accept.
// Backpressure: results are always accepted; queries wait behind in-flight set_cc results (unless CC_FWD_EN) and unconsumed answers.
// Optional macro CC_FWD_EN: forward in-flight flags into the condition evaluator instead of stalling the query.
module alu_cc_unit #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [1:0]        alu_fn,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              set_cc,
  input  logic              cond_valid,
  input  logic [3:0]        cond_ifun,
  output logic              cond_ready,
  output logic              cnd_valid,
  output logic              cnd,
  output logic              cnd_err,
  input  logic              cnd_ready,
  output logic              cc_zf,
  output logic              cc_sf,
  output logic              cc_of,
  output logic [CNT_W-1:0]  upd_cnt
);

  typedef enum logic [1:0] {Q_IDLE, Q_STALL, Q_HOLD} q_state_t;

  q_state_t          q_state;
  logic              rdy_q;
  logic              pend;
  logic [1:0]        s1_fn;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [DATA_W-1:0] s1_res;
  logic              s1_setcc;
  logic              pend_setcc;
  logic              res_acc;
  logic              q_acc;
  logic              hazard;
  logic [2:0]        cmt_flags;
  logic [2:0]        q_flags;
  logic [1:0]        verdict;

  // Flags packed as {zf, sf, of}.
  function automatic logic [2:0] calc_flags(input logic [1:0] fn,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic [DATA_W-1:0] r);
    logic zf;
    logic sf;
    logic of;
    zf = (r == '0);
    sf = r[DATA_W-1];
    case (fn)
      2'd0:    of = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      2'd1:    of = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != b[DATA_W-1]);
      default: of = 1'b0;
    endcase
    return {zf, sf, of};
  endfunction

  // Returns {cnd_err, cnd} for a Y86 ifun against flags {zf, sf, of}.
  function automatic logic [1:0] eval_cnd(input logic [3:0] ifun, input logic [2:0] f);
    logic zf;
    logic lt;
    logic [1:0] r;
    zf = f[2];
    lt = f[1] ^ f[0];
    case (ifun)
      4'd0:    r = 2'b01;
      4'd1:    r = {1'b0, lt | zf};
      4'd2:    r = {1'b0, lt};
      4'd3:    r = {1'b0, zf};
      4'd4:    r = {1'b0, !zf};
      4'd5:    r = {1'b0, !lt};
      4'd6:    r = {1'b0, !lt && !zf};
      default: r = 2'b10;
    endcase
    return r;
  endfunction

  assign res_ready  = rdy_q;
  assign res_acc    = res_valid && rdy_q;
  assign pend_setcc = pend && s1_setcc;
  assign cmt_flags  = calc_flags(s1_fn, s1_a, s1_b, s1_res);
  assign q_acc      = cond_valid && cond_ready;
  assign verdict    = eval_cnd(cond_ifun, q_flags);

`ifdef CC_FWD_EN
  logic [2:0] live_flags;
  assign live_flags = calc_flags(alu_fn, op_a, op_b, alu_res);
  assign hazard     = 1'b0;

  // Evaluate against the flags that will be architectural after this edge.
  always_comb begin
    q_flags = {cc_zf, cc_sf, cc_of};
    if (pend_setcc)
      q_flags = cmt_flags;
    else if (res_acc && set_cc)
      q_flags = live_flags;
  end
`else
  assign hazard  = pend_setcc || (res_valid && set_cc);
  assign q_flags = {cc_zf, cc_sf, cc_of};
`endif

  // Query acceptance: blocked in reset, on a flag hazard, or while an answer is unconsumed.
  always_comb begin
    cond_ready = 1'b0;
    if (reset_n) begin
      case (q_state)
        Q_IDLE, Q_STALL: cond_ready = !hazard;
        Q_HOLD:          cond_ready = cnd_ready && !hazard;
        default:         cond_ready = 1'b0;
      endcase
    end
  end

  // Result path: S1 captures the ALU result, S2 commits flags and bumps the update counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdy_q    <= 1'b0;
      pend     <= 1'b0;
      s1_fn    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_res   <= '0;
      s1_setcc <= 1'b0;
      cc_zf    <= 1'b1;
      cc_sf    <= 1'b0;
      cc_of    <= 1'b0;
      upd_cnt  <= '0;
    end else begin
      rdy_q <= 1'b1;
      pend  <= res_acc;
      if (res_acc) begin
        s1_fn    <= alu_fn;
        s1_a     <= op_a;
        s1_b     <= op_b;
        s1_res   <= alu_res;
        s1_setcc <= set_cc;
      end
      if (pend_setcc) begin
        {cc_zf, cc_sf, cc_of} <= cmt_flags;
        if (upd_cnt != '1)
          upd_cnt <= upd_cnt + CNT_W'(1);
      end
    end
  end

  // Query FSM with registered answer outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_state   <= Q_IDLE;
      cnd_valid <= 1'b0;
      cnd       <= 1'b0;
      cnd_err   <= 1'b0;
    end else begin
      case (q_state)
        Q_IDLE, Q_STALL: begin
          if (q_acc) begin
            {cnd_err, cnd} <= verdict;
            cnd_valid      <= 1'b1;
            q_state        <= Q_HOLD;
          end else if (cond_valid && hazard) begin
            q_state <= Q_STALL;
          end else begin
            q_state <= Q_IDLE;
          end
        end
        Q_HOLD: begin
          if (q_acc) begin
            {cnd_err, cnd} <= verdict;
            cnd_valid      <= 1'b1;
          end else if (cnd_ready) begin
            cnd_valid <= 1'b0;
            q_state   <= Q_IDLE;
          end
        end
        default: begin
          cnd_valid <= 1'b0;
          q_state   <= Q_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cc_unit.sv
// tb_alu_cc_unit: directed vectors for the condition-code unit with hand-computed flags and verdicts.
// Inputs change 1 time unit after each rising edge; outputs are checked 1 unit after that.
// Build with or without CC_FWD_EN; the simultaneous commit/query vector adapts its expectations.
module tb_alu_cc_unit;

  logic        clk;
  logic        reset_n;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  alu_fn;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic [63:0] alu_res;
  logic        set_cc;
  logic        cond_valid;
  logic [3:0]  cond_ifun;
  logic        cond_ready;
  logic        cnd_valid;
  logic        cnd;
  logic        cnd_err;
  logic        cnd_ready;
  logic        cc_zf;
  logic        cc_sf;
  logic        cc_of;
  logic [15:0] upd_cnt;

  int tests_run = 0;
  int fails     = 0;

  alu_cc_unit #(.DATA_W(64), .CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .alu_fn     (alu_fn),
    .op_a       (op_a),
    .op_b       (op_b),
    .alu_res    (alu_res),
    .set_cc     (set_cc),
    .cond_valid (cond_valid),
    .cond_ifun  (cond_ifun),
    .cond_ready (cond_ready),
    .cnd_valid  (cnd_valid),
    .cnd        (cnd),
    .cnd_err    (cnd_err),
    .cnd_ready  (cnd_ready),
    .cc_zf      (cc_zf),
    .cc_sf      (cc_sf),
    .cc_of      (cc_of),
    .upd_cnt    (upd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_res(input logic [1:0] fn, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] r, input logic sc);
    res_valid = 1'b1;
    alu_fn    = fn;
    op_a      = a;
    op_b      = b;
    alu_res   = r;
    set_cc    = sc;
    tick();
    res_valid = 1'b0;
    set_cc    = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input logic zf, input logic sf, input logic of,
                           input logic [15:0] cnt);
    chk({tag, "_zf"}, cc_zf, zf);
    chk({tag, "_sf"}, cc_sf, sf);
    chk({tag, "_of"}, cc_of, of);
    chk({tag, "_cnt"}, upd_cnt, cnt);
  endtask

  task automatic do_query(input string tag, input logic [3:0] ifun, input logic exp_c,
                          input logic exp_e);
    int waited;
    waited     = 0;
    cond_valid = 1'b1;
    cond_ifun  = ifun;
    #1;
    while (!cond_ready && waited < 8) begin
      tick();
      waited++;
    end
    chk({tag, "_acc"}, cond_ready, 1'b1);
    tick();
    cond_valid = 1'b0;
    chk({tag, "_vld"}, cnd_valid, 1'b1);
    chk({tag, "_cnd"}, cnd, exp_c);
    chk({tag, "_err"}, cnd_err, exp_e);
    cnd_ready = 1'b1;
    tick();
    cnd_ready = 1'b0;
    chk({tag, "_drain"}, cnd_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    res_valid  = 1'b0;
    alu_fn     = 2'd0;
    op_a       = '0;
    op_b       = '0;
    alu_res    = '0;
    set_cc     = 1'b0;
    cond_valid = 1'b0;
    cond_ifun  = 4'd0;
    cnd_ready  = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_res_ready", res_ready, 1'b0);
    chk("rst_cond_ready", cond_ready, 1'b0);
    reset_n = 1'b1;
    #1;
    chk_flags("rst", 1'b1, 1'b0, 1'b0, 16'd0);
    chk("rst_cnd_valid", cnd_valid, 1'b0);
    tick();
    chk("rel_res_ready", res_ready, 1'b1);

    // add overflow into sign bit
    send_res(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b1);
    tick();
    chk_flags("add_ovf", 1'b0, 1'b1, 1'b1, 16'd1);
    do_query("add_l",  4'd2, 1'b0, 1'b0);
    do_query("add_le", 4'd1, 1'b0, 1'b0);
    do_query("add_g",  4'd6, 1'b1, 1'b0);
    do_query("add_mp", 4'd0, 1'b1, 1'b0);

    // xor to zero, plus illegal ifun codes
    send_res(2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    tick();
    chk_flags("xor_zero", 1'b1, 1'b0, 1'b0, 16'd2);
    do_query("xor_e",   4'd3,  1'b1, 1'b0);
    do_query("xor_ne",  4'd4,  1'b0, 1'b0);
    do_query("xor_i7",  4'd7,  1'b0, 1'b1);
    do_query("xor_i15", 4'd15, 1'b0, 1'b1);

    // Back-to-back: non-updating add, then sub with signed overflow (0x8000.. - 1)
    send_res(2'd0, 64'h1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0);
    send_res(2'd1, 64'h1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    tick();
    chk_flags("sub_ovf", 1'b0, 1'b0, 1'b1, 16'd3);
    do_query("sub_le", 4'd1, 1'b1, 1'b0);
    do_query("sub_g",  4'd6, 1'b0, 1'b0);
    do_query("sub_ge", 4'd5, 1'b0, 1'b0);

    // Same-cycle sub 5-5 and query 'e' while ZF is currently 0
    res_valid  = 1'b1;
    alu_fn     = 2'd1;
    op_a       = 64'd5;
    op_b       = 64'd5;
    alu_res    = 64'd0;
    set_cc     = 1'b1;
    cond_valid = 1'b1;
    cond_ifun  = 4'd3;
    #1;
`ifdef CC_FWD_EN
    chk("haz_rdy0", cond_ready, 1'b1);
    tick();
    res_valid  = 1'b0;
    set_cc     = 1'b0;
    cond_valid = 1'b0;
`else
    chk("haz_rdy0", cond_ready, 1'b0);
    tick();
    res_valid = 1'b0;
    set_cc    = 1'b0;
    #1;
    chk("haz_rdy1", cond_ready, 1'b0);
    tick();
    chk("haz_rdy2", cond_ready, 1'b1);
    chk("haz_zf", cc_zf, 1'b1);
    tick();
    cond_valid = 1'b0;
`endif
    chk("haz_vld", cnd_valid, 1'b1);
    chk("haz_cnd", cnd, 1'b1);
    cnd_ready = 1'b1;
    tick();
    cnd_ready = 1'b0;
    chk_flags("haz_post", 1'b1, 1'b0, 1'b0, 16'd4);

    // Answer held under backpressure, then back-to-back accept
    cond_valid = 1'b1;
    cond_ifun  = 4'd4;
    tick();
    cond_ifun = 4'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_vld", cnd_valid, 1'b1);
      chk("hold_cnd", cnd, 1'b0);
      chk("hold_err", cnd_err, 1'b0);
      chk("hold_rdy", cond_ready, 1'b0);
      tick();
    end
    cnd_ready = 1'b1;
    #1;
    chk("b2b_rdy", cond_ready, 1'b1);
    tick();
    cond_valid = 1'b0;
    cnd_ready  = 1'b0;
    chk("b2b_vld", cnd_valid, 1'b1);
    chk("b2b_cnd", cnd, 1'b1);
    cnd_ready = 1'b1;
    tick();
    cnd_ready = 1'b0;
    chk("b2b_drain", cnd_valid, 1'b0);

    // Reset with an answer held and a set_cc result in flight
    cond_valid = 1'b1;
    cond_ifun  = 4'd0;
    tick();
    cond_valid = 1'b0;
    chk("mid_vld", cnd_valid, 1'b1);
    send_res(2'd0, 64'h1, 64'h1, 64'h2, 1'b1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    chk("mid_rst_vld", cnd_valid, 1'b0);
    chk("mid_rst_cnd", cnd, 1'b0);
    chk_flags("mid_rst", 1'b1, 1'b0, 1'b0, 16'd0);
    tick();
    tick();
    chk_flags("mid_late", 1'b1, 1'b0, 1'b0, 16'd0);
    chk("mid_res_ready", res_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/alu_cc_unit.md
Name: alu_cc_unit

Overview:
Consumer end of the Y86-64 ALU result path, sitting in the execute stage after the 64-bit ALU (add/sub/and/xor).
- Accepts ALU results over a valid/ready handshake.
- Derives ZF/SF/OF and holds them in the condition-code register.
- Answers condition queries for jXX/cmovXX over a second handshake, resolving the result-to-query hazard itself.

Parameters:
DATA_W, 64, operand/result width
CNT_W, 16, width of saturating CC-update counter

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  synchronous active-low reset
res_valid  in  1  ALU result present
res_ready  out  1  unit accepts result
alu_fn  in  2  0=add 1=sub 2=and 3=xor
op_a  in  DATA_W  ALU operand A (valA)
op_b  in  DATA_W  ALU operand B (valB)
alu_res  in  DATA_W  ALU result (add: b+a, sub: b-a)
set_cc  in  1  result updates CC
cond_valid  in  1  condition query present
cond_ifun  in  4  Y86 ifun condition code
cond_ready  out  1  query accepted this cycle
cnd_valid  out  1  condition answer present
cnd  out  1  condition outcome
cnd_err  out  1  ifun illegal (>6)
cnd_ready  in  1  downstream takes answer
cc_zf, cc_sf, cc_of  out  1 each  architectural flags
upd_cnt  out  CNT_W  number of CC updates, saturating

Behaviour:
Reset (reset_n=0 at rising edge) forces these values, with any in-flight capture or answer discarded:
- cc_zf=1, cc_sf=0, cc_of=0
- cnd_valid=0, cnd=0, cnd_err=0
- upd_cnt=0
- res_ready=0; cond_ready=0 combinationally while reset_n=0

Result path, 2-stage:
- S1 capture: on res_valid&&res_ready, register alu_fn, op_a, op_b, alu_res, set_cc; pend=1.
- S2 commit, next edge: if captured set_cc=1, write flags and increment upd_cnt (saturates at all-ones); pend=0.
- Flag rules:
  - ZF = (res==0)
  - SF = res[63]
  - OF for add = (a[63]==b[63]) && (res[63]!=a[63])
  - OF for sub = (a[63]!=b[63]) && (res[63]!=b[63])
  - OF for and/xor = 0
- res_ready=1 in every non-reset cycle; back-to-back results are sustained at 1 per cycle.
- Flags are visible on cc_* one edge after commit, i.e. 2 edges after acceptance.
- A result with set_cc=0 leaves the flags and upd_cnt untouched.

Query path FSM: Q_IDLE, Q_STALL, Q_HOLD.
- Q_IDLE:
  - cond_ready = !hazard, where hazard = pend_setcc || (res_valid && set_cc).
  - On accept, compute cnd from current flags; register cnd, cnd_err; cnd_valid=1; go to Q_HOLD.
  - If cond_valid && hazard, go to Q_STALL.
- Q_STALL: cond_ready=0 until hazard clears, then behave as Q_IDLE.
- Q_HOLD:
  - cnd, cnd_err and cnd_valid stay stable until cnd_valid&&cnd_ready.
  - cond_ready=0, except on the cycle cnd_ready=1 with no hazard, which allows back-to-back accept.
  - If the answer is consumed and no new query is accepted, go to Q_IDLE.
- Conditions (cnd):
  - 0 always: 1
  - 1 le: (SF^OF)|ZF
  - 2 l: SF^OF
  - 3 e: ZF
  - 4 ne: !ZF
  - 5 ge: !(SF^OF)
  - 6 g: !(SF^OF)&!ZF
  - 7..15: cnd=0, cnd_err=1
- Simultaneous commit and query: the query always observes the post-commit flags; it never sees stale flags.
- Reset mid-operation, including Q_STALL/Q_HOLD: the pending result is dropped; the FSM goes to Q_IDLE.

Optional Feature:
Macro CC_FWD_EN.
- Defined:
  - hazard never stalls; cond_ready = state-based only.
  - cnd is evaluated from the flags about to be committed: S2 flags when pend_setcc, otherwise S1 flags computed from the live inputs.
  - Answer latency is 1 edge regardless of in-flight updates.
- Undefined: stall behaviour as above; the query waits up to 2 cycles behind a set_cc result.
- Architectural flags and upd_cnt are identical either way.

Test Plan:
1. Hold reset_n=0 for 2 cycles, then release -> cc_zf=1, cc_sf=0, cc_of=0, cnd_valid=0, upd_cnt=0; res_ready=1 the cycle after release.
2. add a=0x7FFFFFFFFFFFFFFF, b=1, res=0x8000000000000000, set_cc=1 -> 2 edges later zf=0, sf=1, of=1, upd_cnt=1; query ifun=2 -> cnd=0; ifun=1 -> cnd=0; ifun=6 -> cnd=1.
3. xor a=b=0xFFFFFFFFFFFFFFFF, res=0, set_cc=1 -> zf=1, sf=0, of=0; query ifun=3 -> cnd=1; ifun=7 -> cnd=0, cnd_err=1.
4. Same cycle: sub a=5, b=5, res=0, set_cc=1 plus query ifun=3 -> without CC_FWD_EN, cond_ready=0 for 2 cycles then cnd=1; with CC_FWD_EN, accepted immediately, cnd=1 next edge.
5. Answer pending, cnd_ready=0 for 3 cycles -> cnd_valid=1 and cnd/cnd_err stable, cond_ready=0; raise cnd_ready with a new query waiting -> back-to-back accept.
6. Accept result set_cc=1, then reset_n=0 the next cycle -> flags stay at reset values, upd_cnt=0, no late commit after release.
